ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the 32KB main RAM between the M65C02 core and one DMA requester (video/loader).
//  Sits between the CPU bus (addr decode, IO_Op, MC) and the ram instance; replaces direct CPU->RAM wiring.
//  CPU always wins its MC=7/MC=5 slots; DMA uses free slots, so the CPU never sees a wait state.
// PARAMETERS
//  ADDR_WIDTH  15  RAM word address width (32KB)
//  DATA_WIDTH  8   RAM data width
//  STAT_WIDTH  16  width of the saturating statistics counters (RAM_ARB_STATS_EN only)
// PORTS
//  clk          in   1   system clock (25 MHz)
//  rst_n        in   1   asynchronous reset, active-low
//  cpu_addr     in   15  CPU address [14:0]
//  cpu_wdata    in   8   CPU write data
//  cpu_io_op    in   2   M65C02 IO_Op: 00 none, 01 write, 10 read, 11 fetch
//  cpu_mc       in   3   M65C02 MC; sequence 4->6->7->5->4
//  cpu_ram_cs   in   1   address decoder RAM select
//  cpu_rdata    out  8   = ram_rdata (combinational; the CPU data register captures it at MC=5)
//  dma_req      in   1   DMA request; held high with addr/we/wdata stable until dma_ack
//  dma_we       in   1   1 = write, 0 = read
//  dma_addr     in   15  DMA address
//  dma_wdata    in   8   DMA write data
//  dma_ack      out  1   one-cycle pulse: access complete
//  dma_rdata    out  8   read data, valid while dma_ack=1 for reads; held until the next read completes
//  ram_addr     out  15  to RAM
//  ram_wdata    out  8   to RAM
//  ram_we       out  1   to RAM
//  ram_rdata    in   8   from RAM (synchronous read, 1-cycle latency)
//  dma_owner    out  1   1 while DMA drives the RAM (debug LED)
// BEHAVIOUR
//  - cpu_active = cpu_ram_cs && cpu_io_op != 00. The CPU owns the RAM in MC=7 and MC=5 when cpu_active.
//  - CPU write strobe: ram_we = 1 when cpu_active && io_op == 01 && mc == 7; one cycle per write.
//  - FSM states: IDLE, GRANT, DATA (2-bit reg). Reset state is IDLE.
//  - next_free = (mc == 5) || (mc == 4) || !cpu_active. This is the slot check for the following cycle.
//  - IDLE -> GRANT when dma_req && next_free; otherwise stay in IDLE.
//  - GRANT, exactly 1 cycle:
//    - ram_addr = dma_addr, ram_wdata = dma_wdata, ram_we = dma_we, dma_owner = 1.
//    - Always -> DATA.
//  - DATA, 1 cycle:
//    - RAM is CPU-driven again. dma_ack = 1.
//    - Read: dma_rdata <= ram_rdata at the end of the cycle; the value also passes through during DATA.
//    - Always -> IDLE.
//  - Outside GRANT: ram_addr = cpu_addr, ram_wdata = cpu_wdata.
//  - Throughput: one DMA access per 3 cycles max; request-to-ack latency is 2 cycles when the slot is free.
//  - DMA must deassert or change dma_req only in the cycle after dma_ack. A req still high in IDLE is a new request.
//  - MC values 0-3 (not expected): next_free follows !cpu_active only.
//  - Reset (async, any state):
//    - FSM -> IDLE. No dma_ack is emitted for an aborted access.
//    - Reset values: dma_ack = 0, dma_owner = 0, ram_we = 0, dma_rdata = 8'h00.
//    - ram_addr/ram_wdata follow the CPU inputs.
//  - CPU writes and DMA writes to the same address never collide: the slots are disjoint.
// CONFIGURATION
//  RAM_ARB_STATS_EN defined:
//    - Adds ports stat_grants (out, STAT_WIDTH): count of completed DMA accesses.
//    - Adds ports stat_stalls (out, STAT_WIDTH): cycles in IDLE with dma_req=1 and !next_free.
//    - Both counters saturate at all-ones and reset to 0.
//  RAM_ARB_STATS_EN undefined: no counters and no stat_* ports. Arbitration is identical.
// STRUCTURE
//  - Package ram_arb_pkg holds:
//    - IO_OP_NONE/WRITE/READ/FETCH, MC_CYC1=6, MC_CYC2=7, MC_CYC3=5, MC_CYC4=4
//    - state enum ARB_IDLE/ARB_GRANT/ARB_DATA
//  - Sub-module ram_arb_stats holds the two saturating counters; instantiated only under RAM_ARB_STATS_EN.
// TESTING
//  - CPU only: write $55 to $0010 at MC=7, then read -> ram_we high exactly at MC=7; cpu_rdata=$55 at MC=5.
//  - DMA read with CPU idle (io_op=00): dma_req, addr $1234 holding $A5 -> GRANT next cycle, dma_ack 2 cycles after req, dma_rdata=$A5.
//  - DMA req raised at MC=6 with CPU reading RAM -> no grant in MC=7/MC=5; GRANT during MC=4; CPU still reads the correct byte.
//  - Interleave: CPU writes $11 to $0100, DMA writes $22 to $0101 in the same microcycle -> both bytes land; ram_we never drives the wrong address.
//  - Assert rst_n low during GRANT -> dma_ack never pulses, ram_we=0 immediately; after release a re-held req completes.
//  - RAM_ARB_STATS_EN: 3 DMA accesses, one blocked for 2 cycles -> stat_grants=3, stat_stalls=2; force 2^16 grants -> stat_grants holds at $FFFF.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM arbiter: M65C02 IO_Op and MC values plus the arbiter FSM states.
package ram_arb_pkg;

    localparam logic [1:0] IO_OP_NONE  = 2'b00;
    localparam logic [1:0] IO_OP_WRITE = 2'b01;
    localparam logic [1:0] IO_OP_READ  = 2'b10;
    localparam logic [1:0] IO_OP_FETCH = 2'b11;

    localparam logic [2:0] MC_CYC1 = 3'd6;
    localparam logic [2:0] MC_CYC2 = 3'd7;
    localparam logic [2:0] MC_CYC3 = 3'd5;
    localparam logic [2:0] MC_CYC4 = 3'd4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arb_stats.sv
// Saturating DMA statistics: completed accesses and cycles a pending request waited for a CPU slot.
module ram_arb_stats #(
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  grant_evt_i,
    input  logic                  stall_evt_i,
    output logic [STAT_WIDTH-1:0] grants_o,
    output logic [STAT_WIDTH-1:0] stalls_o
);

    logic [STAT_WIDTH-1:0] grants_q, grants_d;
    logic [STAT_WIDTH-1:0] stalls_q, stalls_d;

    always_comb begin
        grants_d = grants_q;
        stalls_d = stalls_q;
        if (grant_evt_i && (grants_q != '1)) grants_d = grants_q + STAT_WIDTH'(1);
        if (stall_evt_i && (stalls_q != '1)) stalls_d = stalls_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else begin
            grants_q <= grants_d;
            stalls_q <= stalls_d;
        end
    end

    assign grants_o = grants_q;
    assign stalls_o = stalls_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares main RAM between the M65C02 (owns MC=7/MC=5 when active) and one DMA requester.
// Defining RAM_ARB_STATS_EN adds the stat_grants/stat_stalls saturating counters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [1:0]            cpu_io_op,
    input  logic [2:0]            cpu_mc,
    input  logic                  cpu_ram_cs,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  dma_owner
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_grants,
    output logic [STAT_WIDTH-1:0] stat_stalls
`endif
);

    arb_state_e            state_q, state_d;
    logic                  dma_ack_q;
    logic                  dma_owner_q;
    logic [DATA_WIDTH-1:0] dma_rdata_q;
    logic                  cpu_active;
    logic                  cpu_wr_strobe;
    logic                  next_free;

    assign cpu_active    = cpu_ram_cs && (cpu_io_op != IO_OP_NONE);
    assign cpu_wr_strobe = cpu_active && (cpu_io_op == IO_OP_WRITE) && (cpu_mc == MC_CYC2);

    // Looks one cycle ahead: MC=5 is followed by 4 and MC=4 by 6, neither of which the CPU owns.
    assign next_free = (cpu_mc == MC_CYC3) || (cpu_mc == MC_CYC4) || !cpu_active;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (dma_req && next_free) state_d = ARB_GRANT;
            ARB_GRANT: state_d = ARB_DATA;
            ARB_DATA:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            dma_ack_q   <= 1'b0;
            dma_owner_q <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dma_owner_q <= (state_d == ARB_GRANT);
            dma_ack_q   <= (state_d == ARB_DATA);
            if ((state_q == ARB_DATA) && !dma_we) dma_rdata_q <= ram_rdata;
        end
    end

    assign ram_addr  = (state_q == ARB_GRANT) ? dma_addr  : cpu_addr;
    assign ram_wdata = (state_q == ARB_GRANT) ? dma_wdata : cpu_wdata;
    // Gated by rst_n so a CPU write strobe cannot reach the RAM while reset is asserted.
    assign ram_we    = rst_n && ((state_q == ARB_GRANT) ? dma_we : cpu_wr_strobe);

    assign cpu_rdata = ram_rdata;
    assign dma_ack   = dma_ack_q;
    assign dma_owner = dma_owner_q;
    assign dma_rdata = (dma_ack_q && !dma_we) ? ram_rdata : dma_rdata_q;

`ifdef RAM_ARB_STATS_EN
    ram_arb_stats #(
        .STAT_WIDTH(STAT_WIDTH)
    ) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant_evt_i(state_q == ARB_DATA),
        .stall_evt_i((state_q == ARB_IDLE) && dma_req && !next_free),
        .grants_o   (stat_grants),
        .stalls_o   (stat_stalls)
    );
`endif

endmodule
